card_slot_scheduler: RTL and testbench

- Schedules which card sprite the image-draw pipeline renders at each pixel.
- Game logic writes card placements (slot, x, y, card id, visible) into a pending table through a valid/ready handshake.
- On each vertical-blank entry the block copies the pending table into the active table, one slot per cycle, so a frame is never torn.
- During scan it compares hcount/vcount against the active slots and drives the winning slot's xpos/ypos/card id to the downstream card-image ROM reader.

---
 rtl/card_slot_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_card_slot_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_slot_scheduler.sv
// Card sprite slot scheduler: double-buffered slot table, committed on vblank entry, with per-pixel hit lookup.
// Lookup outputs are registered, one cycle after hcount/vcount; wr_ready drops during COMMIT/CLEAR; optional hold_in via CARD_SCHED_HOLD_EN.
module card_slot_scheduler #(
    parameter int N_SLOTS = 8,
    parameter int CARD_W  = 64,
    parameter int CARD_H  = 96,
    parameter int ID_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [10:0]                hcount_in,
    input  logic [10:0]                vcount_in,
    input  logic                       vblnk_in,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(N_SLOTS)-1:0] wr_slot,
    input  logic [10:0]                wr_x,
    input  logic [10:0]                wr_y,
    input  logic [ID_W-1:0]            wr_id,
    input  logic                       wr_vis,
    input  logic                       clear_req,
`ifdef CARD_SCHED_HOLD_EN
    input  logic                       hold_in,
`endif
    output logic                       hit_out,
    output logic [10:0]                xpos_out,
    output logic [10:0]                ypos_out,
    output logic [ID_W-1:0]            id_out,
    output logic                       busy_out
);

    localparam int            SW       = $clog2(N_SLOTS);
    localparam logic [SW-1:0] LAST_IDX = SW'(N_SLOTS - 1);
    localparam logic [10:0]   CARD_W_L = 11'(CARD_W);
    localparam logic [10:0]   CARD_H_L = 11'(CARD_H);

    typedef struct packed {
        logic            vis;
        logic [10:0]     x;
        logic [10:0]     y;
        logic [ID_W-1:0] id;
    } slot_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        COMMIT = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   idx_q, idx_d;
    logic            commit_pend_q, commit_pend_d;
    logic            vblnk_prev_q, vblnk_prev_d;
    slot_t           pend_q [N_SLOTS];
    slot_t           pend_d [N_SLOTS];
    slot_t           act_q  [N_SLOTS];
    slot_t           act_d  [N_SLOTS];
    logic            hit_q, hit_d;
    logic [10:0]     xpos_q, xpos_d;
    logic [10:0]     ypos_q, ypos_d;
    logic [ID_W-1:0] id_q, id_d;

    logic vblnk_rise;
    logic hold_active;

    assign vblnk_rise = vblnk_in && !vblnk_prev_q;

`ifdef CARD_SCHED_HOLD_EN
    assign hold_active = hold_in;
`else
    assign hold_active = 1'b0;
`endif

    // Control FSM and table updates
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        commit_pend_d = commit_pend_q;
        vblnk_prev_d  = vblnk_in;
        pend_d        = pend_q;
        act_d         = act_q;
        wr_ready      = 1'b0;

        case (state_q)
            RUN: begin
                wr_ready = !rst && !clear_req;
                if (wr_valid && wr_ready) begin
                    pend_d[wr_slot] = '{vis: wr_vis, x: wr_x, y: wr_y, id: wr_id};
                end
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                    if (vblnk_rise) begin
                        commit_pend_d = 1'b1;
                    end
                end else if (hold_active) begin
                    // Defer the swap so a multi-slot deal lands in a single frame.
                    if (vblnk_rise) begin
                        commit_pend_d = 1'b1;
                    end
                end else if (vblnk_rise || commit_pend_q) begin
                    state_d       = COMMIT;
                    idx_d         = '0;
                    commit_pend_d = 1'b0;
                end
            end

            COMMIT: begin
                act_d[idx_q] = pend_q[idx_q];
                idx_d        = idx_q + SW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end

            CLEAR: begin
                pend_d[idx_q].vis = 1'b0;
                idx_d             = idx_q + SW'(1);
                if (vblnk_rise) begin
                    commit_pend_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end

            default: begin
                state_d = RUN;
                idx_d   = '0;
            end
        endcase
    end

    // Pixel lookup; ascending scan lets the highest-index hit win.
    always_comb begin
        logic [10:0] dx;
        logic [10:0] dy;
        dx     = '0;
        dy     = '0;
        hit_d  = 1'b0;
        xpos_d = '0;
        ypos_d = '0;
        id_d   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            dx = hcount_in - act_q[i].x;
            dy = vcount_in - act_q[i].y;
            if (act_q[i].vis && (dx < CARD_W_L) && (dy < CARD_H_L)) begin
                hit_d  = 1'b1;
                xpos_d = act_q[i].x;
                ypos_d = act_q[i].y;
                id_d   = act_q[i].id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            idx_q         <= '0;
            commit_pend_q <= 1'b0;
            vblnk_prev_q  <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
            hit_q  <= 1'b0;
            xpos_q <= '0;
            ypos_q <= '0;
            id_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            commit_pend_q <= commit_pend_d;
            vblnk_prev_q  <= vblnk_prev_d;
            pend_q        <= pend_d;
            act_q         <= act_d;
            hit_q         <= hit_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            id_q          <= id_d;
        end
    end

    assign hit_out  = hit_q;
    assign xpos_out = xpos_q;
    assign ypos_out = ypos_q;
    assign id_out   = id_q;
    assign busy_out = (state_q != RUN);

endmodule

// File: tb/tb_card_slot_scheduler.sv
// Bench for card_slot_scheduler: directed scenarios plus random traffic against a table-level reference model.
module tb_card_slot_scheduler;

    localparam int N  = 8;
    localparam int CW = 64;
    localparam int CH = 96;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [10:0]   hcount_in = '0;
    logic [10:0]   vcount_in = '0;
    logic          vblnk_in = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [2:0]    wr_slot = '0;
    logic [10:0]   wr_x = '0;
    logic [10:0]   wr_y = '0;
    logic [IW-1:0] wr_id = '0;
    logic          wr_vis = 1'b0;
    logic          clear_req = 1'b0;
`ifdef CARD_SCHED_HOLD_EN
    logic          hold_in = 1'b0;
`endif
    logic          hit_out;
    logic [10:0]   xpos_out;
    logic [10:0]   ypos_out;
    logic [IW-1:0] id_out;
    logic          busy_out;

    card_slot_scheduler #(.N_SLOTS(N), .CARD_W(CW), .CARD_H(CH), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .vblnk_in(vblnk_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_slot(wr_slot), .wr_x(wr_x), .wr_y(wr_y), .wr_id(wr_id), .wr_vis(wr_vis),
        .clear_req(clear_req),
`ifdef CARD_SCHED_HOLD_EN
        .hold_in(hold_in),
`endif
        .hit_out(hit_out), .xpos_out(xpos_out), .ypos_out(ypos_out),
        .id_out(id_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vis;
        int x;
        int y;
        int id;
    } card_t;

    typedef struct packed {
        logic          hit;
        logic [10:0]   x;
        logic [10:0]   y;
        logic [IW-1:0] id;
    } look_t;

    card_t pend_m [N];
    card_t act_m  [N];
    look_t exp_q  [$];
    int    checks   = 0;
    int    failures = 0;

    function automatic look_t model_lookup(int h, int v);
        look_t r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (act_m[i].vis && (((h - act_m[i].x) & 2047) < CW) && (((v - act_m[i].y) & 2047) < CH)) begin
                r.hit = 1'b1;
                r.x   = 11'(act_m[i].x);
                r.y   = 11'(act_m[i].y);
                r.id  = IW'(act_m[i].id);
                return r;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            pend_m[i] = '{0, 0, 0, 0};
            act_m[i]  = '{0, 0, 0, 0};
        end
    endtask

    // Monitor: every queued probe is due one cycle after it was driven.
    initial begin
        look_t e;
        look_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {hit_out, xpos_out, ypos_out, id_out};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL lookup: got hit=%0d x=%0d y=%0d id=%0d, expected hit=%0d x=%0d y=%0d id=%0d",
                             a.hit, a.x, a.y, a.id, e.hit, e.x, e.y, e.id);
                end
            end
        end
    end

    task automatic probe(input int h, input int v);
        @(negedge clk);
        hcount_in = 11'(h & 2047);
        vcount_in = 11'(v & 2047);
        exp_q.push_back(model_lookup(h & 2047, v & 2047));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("wr_ready_in_reset", int'(wr_ready), 0);
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({hit_out, xpos_out, ypos_out, id_out, busy_out}), 0);
        rst = 1'b0;
        #1;
        check("wr_ready_after_reset", int'(wr_ready), 1);
        model_reset();
    endtask

    task automatic write_slot(input int s, input int x, input int y, input int id, input bit vis);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_slot  = 3'(s);
        wr_x     = 11'(x);
        wr_y     = 11'(y);
        wr_id    = IW'(id);
        wr_vis   = vis;
        #1;
        check("wr_ready_run", int'(wr_ready), 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        pend_m[s] = '{vis, x & 2047, y & 2047, id & ((1 << IW) - 1)};
    endtask

    // Raise vblank, count busy cycles, then the whole pending table is visible.
    task automatic vblank_commit();
        int n;
        int bad;
        n   = 0;
        bad = 0;
        @(negedge clk);
        vblnk_in = 1'b1;
        for (int c = 0; c < 4 * N; c++) begin
            @(negedge clk);
            if (busy_out) begin
                n++;
                if (wr_ready) bad++;
            end
        end
        vblnk_in = 1'b0;
        check("commit_busy_cycles", n, N);
        check("commit_wr_ready_low", bad, 0);
        for (int i = 0; i < N; i++) act_m[i] = pend_m[i];
    endtask

    task automatic clear_only();
        int n;
        n = 0;
        @(negedge clk);
        clear_req = 1'b1;
        #1;
        check("clear_wr_ready", int'(wr_ready), 0);
        for (int c = 0; c < 3 * N; c++) begin
            @(negedge clk);
            if (c == 0) clear_req = 1'b0;
            if (busy_out) n++;
        end
        check("clear_busy_cycles", n, N);
        for (int i = 0; i < N; i++) pend_m[i].vis = 1'b0;
    endtask

    task automatic clear_with_vblank();
        int n;
        n = 0;
        @(negedge clk);
        clear_req = 1'b1;
        vblnk_in  = 1'b1;
        #1;
        check("clear_vblank_wr_ready", int'(wr_ready), 0);
        for (int c = 0; c < 6 * N; c++) begin
            @(negedge clk);
            if (c == 0) clear_req = 1'b0;
            if (busy_out) n++;
        end
        vblnk_in = 1'b0;
        check("clear_then_commit_busy", n, 2 * N);
        for (int i = 0; i < N; i++) begin
            pend_m[i].vis = 1'b0;
            act_m[i]      = pend_m[i];
        end
    endtask

    task automatic reset_mid_commit();
        int n;
        int guard;
        n     = 0;
        guard = 0;
        @(negedge clk);
        vblnk_in = 1'b1;
        while (n < 4 && guard < 4 * N) begin
            @(negedge clk);
            guard++;
            if (busy_out) n++;
        end
        check("reached_commit_cycle4", n, 4);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", int'({hit_out, xpos_out, ypos_out, id_out, busy_out}), 0);
        vblnk_in = 1'b0;
        rst      = 1'b0;
        #1;
        check("abort_wr_ready", int'(wr_ready), 1);
        model_reset();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int s;
        model_reset();
        do_reset();

        // Single card, exact corner and right-edge miss
        write_slot(0, 100, 200, 5, 1'b1);
        vblank_commit();
        probe(100, 200);
        probe(164, 200);
        probe(163, 295);

        // Overlap: higher slot wins
        write_slot(1, 120, 200, 9, 1'b1);
        vblank_commit();
        probe(130, 210);
        probe(110, 210);

        // Pending write is invisible until the next commit
        write_slot(2, 300, 400, 7, 1'b1);
        probe(310, 410);
        vblank_commit();
        probe(310, 410);

        // Last write to a slot wins
        write_slot(3, 500, 500, 11, 1'b1);
        write_slot(3, 600, 600, 12, 1'b1);
        vblank_commit();
        probe(510, 510);
        probe(610, 610);

        // Wrap at the left/top edges and at the far right of the coordinate space
        probe(99, 200);
        probe(100, 296);
        write_slot(4, 2000, 300, 33, 1'b1);
        vblank_commit();
        probe(2047, 300);
        probe(1999, 300);

        // Clear together with a vblank edge, then deferred commit
        clear_with_vblank();
        probe(130, 210);
        probe(310, 410);
        probe(2047, 300);

        // Reset aborting a commit
        write_slot(5, 700, 100, 21, 1'b1);
        vblank_commit();
        write_slot(6, 800, 100, 22, 1'b1);
        reset_mid_commit();
        probe(710, 110);
        probe(810, 110);

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 99));
            s = int'($urandom_range(0, N - 1));
            if (r < 35) begin
                write_slot(s, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                           int'($urandom_range(0, 63)), bit'($urandom_range(0, 3) != 0));
            end else if (r < 85) begin
                if ($urandom_range(0, 1) == 1)
                    probe(act_m[s].x + int'($urandom_range(0, 80)) - 8, act_m[s].y + int'($urandom_range(0, 110)) - 8);
                else
                    probe(pend_m[s].x + int'($urandom_range(0, 80)) - 8, pend_m[s].y + int'($urandom_range(0, 110)) - 8);
            end else if (r < 95) begin
                vblank_commit();
            end else begin
                clear_only();
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
